// File: rtl/trap_pkg.sv
// Shared CSR addresses, mstatus field positions, FSM encoding and mstatus
// update helpers for the machine-mode trap sequencer.
package trap_pkg;

   localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
   localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MPP_HI   = 12;
   localparam int MPP_LO   = 11;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_T_RD_MST  = 4'd1,
      S_T_WR_MEPC = 4'd2,
      S_T_WR_MCAUSE = 4'd3,
      S_T_WR_MST  = 4'd4,
      S_T_RD_TVEC = 4'd5,
      S_T_REDIR   = 4'd6,
      S_M_RD_MST  = 4'd7,
      S_M_RD_EPC  = 4'd8,
      S_M_WR_MST  = 4'd9,
      S_M_REDIR   = 4'd10
   } state_e;

   // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
      logic [31:0] r;
      r = m;
      r[MPIE_BIT] = m[MIE_BIT];
      r[MIE_BIT] = 1'b0;
      r[MPP_HI:MPP_LO] = 2'b11;
      return r;
   endfunction

   // mret: restore MIE from MPIE, re-arm MPIE, machine-only so MPP stays M.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
      logic [31:0] r;
      r = m;
      r[MIE_BIT] = m[MPIE_BIT];
      r[MPIE_BIT] = 1'b1;
      r[MPP_HI:MPP_LO] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/trap_vec_calc.sv
// Combinational trap target: vectored mode only for interrupts, every other
// mode (including reserved 2/3) jumps to the aligned base.
module trap_vec_calc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] cause,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   always_comb begin
      base   = {mtvec[XLEN-1:2], 2'b00};
      offset = {cause[XLEN-3:0], 2'b00};
      if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
         target = base + offset;
      else
         target = base;
   end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer owning the CSR file port; the core's CSR
// path gets the port combinationally whenever no sequence is active or pending.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            exc_valid_i,
   input  logic [XLEN-1:0] exc_cause_i,
   input  logic [XLEN-1:0] exc_pc_i,
   output logic            exc_ack_o,
   input  logic            mret_i,
   output logic            mret_ack_o,
   input  logic            core_req_i,
   input  logic [XLEN-1:0] core_addr_i,
   input  logic            core_we_i,
   input  logic            core_re_i,
   input  logic [XLEN-1:0] core_wdata_i,
   output logic            core_gnt_o,
   output logic [XLEN-1:0] csr_addr_o,
   output logic            csr_we_o,
   output logic            csr_re_o,
   output logic [XLEN-1:0] csr_wdata_o,
   input  logic [XLEN-1:0] csr_rdata_i,
   output logic            busy_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] mst_q;
   logic [XLEN-1:2] epc_q;
   logic [XLEN-1:0] vec_target;
   logic            idle;

   trap_vec_calc #(.XLEN(XLEN)) u_vec (
      .mtvec  (csr_rdata_i),
      .cause  (cause_q),
      .target (vec_target)
   );

   assign idle       = (state_q == S_IDLE);
   assign busy_o     = ~idle;
   assign exc_ack_o  = idle & exc_valid_i;
   assign mret_ack_o = idle & mret_i & ~exc_valid_i;
   assign core_gnt_o = idle & core_req_i & ~exc_valid_i & ~mret_i;

   always_comb begin
      state_d          = state_q;
      csr_addr_o       = '0;
      csr_we_o         = 1'b0;
      csr_re_o         = 1'b0;
      csr_wdata_o      = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state_q)
         S_IDLE: begin
            if (exc_valid_i)
               state_d = S_T_RD_MST;
            else if (mret_i)
               state_d = S_M_RD_MST;
            else if (core_req_i) begin
               csr_addr_o  = core_addr_i;
               csr_we_o    = core_we_i;
               csr_re_o    = core_re_i;
               csr_wdata_o = core_wdata_i;
            end
         end
         S_T_RD_MST: begin
            csr_addr_o = CSR_MSTATUS;
            csr_re_o   = 1'b1;
            state_d    = S_T_WR_MEPC;
         end
         S_T_WR_MEPC: begin
            csr_addr_o  = CSR_MEPC;
            csr_we_o    = 1'b1;
            csr_wdata_o = pc_q;
            state_d     = S_T_WR_MCAUSE;
         end
         S_T_WR_MCAUSE: begin
            csr_addr_o  = CSR_MCAUSE;
            csr_we_o    = 1'b1;
            csr_wdata_o = cause_q;
            state_d     = S_T_WR_MST;
         end
         S_T_WR_MST: begin
            csr_addr_o  = CSR_MSTATUS;
            csr_we_o    = 1'b1;
            csr_wdata_o = trap_mstatus(mst_q);
            state_d     = S_T_RD_TVEC;
         end
         S_T_RD_TVEC: begin
            csr_addr_o = CSR_MTVEC;
            csr_re_o   = 1'b1;
            state_d    = S_T_REDIR;
         end
         // mtvec arrives on csr_rdata_i this cycle and feeds the target directly.
         S_T_REDIR: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = vec_target;
            state_d          = S_IDLE;
         end
         S_M_RD_MST: begin
            csr_addr_o = CSR_MSTATUS;
            csr_re_o   = 1'b1;
            state_d    = S_M_RD_EPC;
         end
         S_M_RD_EPC: begin
            csr_addr_o = CSR_MEPC;
            csr_re_o   = 1'b1;
            state_d    = S_M_WR_MST;
         end
         S_M_WR_MST: begin
            csr_addr_o  = CSR_MSTATUS;
            csr_we_o    = 1'b1;
            csr_wdata_o = mret_mstatus(mst_q);
            state_d     = S_M_REDIR;
         end
         S_M_REDIR: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = {epc_q, 2'b00};
            state_d          = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cause_q <= '0;
         pc_q    <= '0;
         mst_q   <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (idle && exc_valid_i) begin
            cause_q <= exc_cause_i;
            pc_q    <= exc_pc_i;
         end
         if (state_q == S_T_WR_MEPC || state_q == S_M_RD_EPC)
            mst_q <= csr_rdata_i;
         if (state_q == S_M_WR_MST)
            epc_q <= csr_rdata_i[XLEN-1:2];
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a small behavioural CSR file on the
// port; CSR contents are preloaded and read back through the core path.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        exc_valid_i;
   logic [31:0] exc_cause_i;
   logic [31:0] exc_pc_i;
   logic        exc_ack_o;
   logic        mret_i;
   logic        mret_ack_o;
   logic        core_req_i;
   logic [31:0] core_addr_i;
   logic        core_we_i;
   logic        core_re_i;
   logic [31:0] core_wdata_i;
   logic        core_gnt_o;
   logic [31:0] csr_addr_o;
   logic        csr_we_o;
   logic        csr_re_o;
   logic [31:0] csr_wdata_o;
   logic [31:0] csr_rdata_i;
   logic        busy_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .exc_valid_i      (exc_valid_i),
      .exc_cause_i      (exc_cause_i),
      .exc_pc_i         (exc_pc_i),
      .exc_ack_o        (exc_ack_o),
      .mret_i           (mret_i),
      .mret_ack_o       (mret_ack_o),
      .core_req_i       (core_req_i),
      .core_addr_i      (core_addr_i),
      .core_we_i        (core_we_i),
      .core_re_i        (core_re_i),
      .core_wdata_i     (core_wdata_i),
      .core_gnt_o       (core_gnt_o),
      .csr_addr_o       (csr_addr_o),
      .csr_we_o         (csr_we_o),
      .csr_re_o         (csr_re_o),
      .csr_wdata_o      (csr_wdata_o),
      .csr_rdata_i      (csr_rdata_i),
      .busy_o           (busy_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   // Behavioural CSR file: one-cycle read latency, writes commit on the edge.
   logic [31:0] m_mst   = '0;
   logic [31:0] m_tvec  = '0;
   logic [31:0] m_epc   = '0;
   logic [31:0] m_cause = '0;

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      case (a)
         32'h300: return m_mst;
         32'h305: return m_tvec;
         32'h341: return m_epc;
         32'h342: return m_cause;
         default: return 32'h0;
      endcase
   endfunction

   initial csr_rdata_i = '0;
   always @(posedge clk) begin
      csr_rdata_i <= csr_re_o ? m_rd(csr_addr_o) : 32'h0;
      if (csr_we_o) begin
         case (csr_addr_o)
            32'h300: m_mst   <= csr_wdata_o;
            32'h305: m_tvec  <= csr_wdata_o;
            32'h341: m_epc   <= csr_wdata_o;
            32'h342: m_cause <= csr_wdata_o;
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {25'b0, exc_ack_o, mret_ack_o, core_gnt_o, csr_we_o,
                          csr_re_o, busy_o, redirect_valid_o}, 32'h0);
      chk({tag, "_addr"}, csr_addr_o, 32'h0);
      chk({tag, "_wdata"}, csr_wdata_o, 32'h0);
      chk({tag, "_rpc"}, redirect_pc_o, 32'h0);
   endtask

   task automatic core_write(input logic [31:0] a, input logic [31:0] d);
      core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = a; core_wdata_i = d;
      #1;
      chk("cw_gnt", core_gnt_o, 32'h1);
      chk("cw_we", csr_we_o, 32'h1);
      chk("cw_addr", csr_addr_o, a);
      chk("cw_wdata", csr_wdata_o, d);
      @(negedge clk);
      core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
   endtask

   task automatic core_read(input logic [31:0] a, input logic [31:0] exp);
      core_req_i = 1'b1; core_re_i = 1'b1; core_addr_i = a;
      #1;
      chk("cr_gnt", core_gnt_o, 32'h1);
      chk("cr_re", csr_re_o, 32'h1);
      @(negedge clk);
      core_req_i = 1'b0; core_re_i = 1'b0; core_addr_i = '0;
      #1;
      chk("cr_data", csr_rdata_i, exp);
      @(negedge clk);
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] exp_mst, input logic [31:0] exp_tgt,
                          input logic contend);
      exc_valid_i = 1'b1; exc_cause_i = cause; exc_pc_i = pc;
      mret_i = contend; core_req_i = contend; core_re_i = contend;
      core_addr_i = 32'h123;
      #1;
      chk("t_ack", exc_ack_o, 32'h1);
      chk("t_mack", mret_ack_o, 32'h0);
      chk("t_gnt", core_gnt_o, 32'h0);
      @(negedge clk);
      exc_valid_i = 1'b0;
      #1;
      chk("t1_ack", exc_ack_o, 32'h0);
      chk("t1_busy", busy_o, 32'h1);
      chk("t1_re", csr_re_o, 32'h1);
      chk("t1_addr", csr_addr_o, 32'h300);
      chk("t1_mack", mret_ack_o, 32'h0);
      chk("t1_gnt", core_gnt_o, 32'h0);
      @(negedge clk); #1;
      chk("t2_we", csr_we_o, 32'h1);
      chk("t2_addr", csr_addr_o, 32'h341);
      chk("t2_wdata", csr_wdata_o, pc);
      @(negedge clk); #1;
      chk("t3_addr", csr_addr_o, 32'h342);
      chk("t3_wdata", csr_wdata_o, cause);
      @(negedge clk); #1;
      chk("t4_we", csr_we_o, 32'h1);
      chk("t4_addr", csr_addr_o, 32'h300);
      chk("t4_wdata", csr_wdata_o, exp_mst);
      @(negedge clk); #1;
      chk("t5_re", csr_re_o, 32'h1);
      chk("t5_addr", csr_addr_o, 32'h305);
      chk("t5_redir", redirect_valid_o, 32'h0);
      @(negedge clk); #1;
      chk("t6_redir", redirect_valid_o, 32'h1);
      chk("t6_pc", redirect_pc_o, exp_tgt);
      chk("t6_mack", mret_ack_o, 32'h0);
      mret_i = 1'b0;
      @(negedge clk); #1;
      chk("t7_redir", redirect_valid_o, 32'h0);
      chk("t7_busy", busy_o, 32'h0);
      if (contend) begin
         chk("t7_gnt", core_gnt_o, 32'h1);
         chk("t7_addr", csr_addr_o, 32'h123);
      end
      core_req_i = 1'b0; core_re_i = 1'b0; core_addr_i = '0;
      @(negedge clk);
   endtask

   task automatic do_mret(input logic [31:0] exp_mst, input logic [31:0] exp_tgt);
      mret_i = 1'b1;
      #1;
      chk("m_ack", mret_ack_o, 32'h1);
      chk("m_eack", exc_ack_o, 32'h0);
      @(negedge clk);
      mret_i = 1'b0;
      #1;
      chk("m1_addr", csr_addr_o, 32'h300);
      chk("m1_re", csr_re_o, 32'h1);
      @(negedge clk); #1;
      chk("m2_addr", csr_addr_o, 32'h341);
      chk("m2_re", csr_re_o, 32'h1);
      @(negedge clk); #1;
      chk("m3_we", csr_we_o, 32'h1);
      chk("m3_addr", csr_addr_o, 32'h300);
      chk("m3_wdata", csr_wdata_o, exp_mst);
      @(negedge clk); #1;
      chk("m4_redir", redirect_valid_o, 32'h1);
      chk("m4_pc", redirect_pc_o, exp_tgt);
      @(negedge clk); #1;
      chk("m5_busy", busy_o, 32'h0);
      chk("m5_redir", redirect_valid_o, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      rst_i = 1'b1;
      exc_valid_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0; mret_i = 1'b0;
      core_req_i = 1'b0; core_addr_i = '0; core_we_i = 1'b0; core_re_i = 1'b0;
      core_wdata_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_zero("rst");
      rst_i = 1'b0;
      @(negedge clk); #1;
      chk_zero("idle");
      @(negedge clk);

      // Direct-mode synchronous exception.
      core_write(32'h300, 32'h8);
      core_write(32'h305, 32'h100);
      do_trap(32'h2, 32'h40, 32'h1880, 32'h100, 1'b0);
      core_read(32'h341, 32'h40);
      core_read(32'h342, 32'h2);
      core_read(32'h300, 32'h1880);

      // Vectored interrupt with trap, mret and core all contending.
      core_write(32'h305, 32'h201);
      do_trap(32'h8000_0007, 32'h80, 32'h1800, 32'h21C, 1'b1);
      // Vectored mtvec but synchronous cause: base only.
      do_trap(32'h5, 32'h84, 32'h1800, 32'h200, 1'b0);

      // mret restores MIE and redirects to aligned mepc.
      core_write(32'h300, 32'h1880);
      core_write(32'h341, 32'h43);
      do_mret(32'h1888, 32'h40);
      core_read(32'h300, 32'h1888);

      // Reset asserted mid-cycle during the mcause write.
      exc_valid_i = 1'b1; exc_cause_i = 32'hB; exc_pc_i = 32'h60;
      @(negedge clk);
      exc_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("r_addr", csr_addr_o, 32'h342);
      #2;
      rst_i = 1'b1;
      #1;
      chk_zero("r_async");
      @(negedge clk);
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("r_noredir", redirect_valid_o, 32'h0);
         chk("r_idle", busy_o, 32'h0);
         @(negedge clk);
      end
      core_read(32'h341, 32'h60);
      core_read(32'h342, 32'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
